// File: rtl/p3_exec_stage.sv
// p3_exec_stage: execute stage of the SIMPLE pipeline.
//
// Takes decoded operands and controls from the p2 decode/register-read stage,
// runs the ALU/shifter, keeps the {S,Z,C,V} flag register, resolves
// conditional branches and retires OUT and HLT. Every result lands in the
// p3->p4 pipeline register one cycle after issue.
//
// Ports:
//   clockp3, reset          stage clock, synchronous active-high reset
//   valid_in, flush         p2 instruction present / kill it
//   alu_class, opcode       class-11 instruction and its command[7:4]
//   alu1, alu2              Rs and Rd/Rb operands
//   writereg_in .. pc_in    control and address fields from p2
//   valid_out .. storedata_out  p4 pipeline register contents
//   flags                   {S,Z,C,V}
//   branch_taken, branch_target  taken-branch pulse and its target
//   outdata, outvalid       OUT port value and update pulse
//   halted                  sticky after HLT until reset
module p3_exec_stage #(
    parameter int WIDTH = 16
) (
    input  logic             clockp3,
    input  logic             reset,
    input  logic             valid_in,
    input  logic             flush,
    input  logic             alu_class,
    input  logic [WIDTH-1:0] alu1,
    input  logic [WIDTH-1:0] alu2,
    input  logic [3:0]       opcode,
    input  logic             writereg_in,
    input  logic [1:0]       memwrite_in,
    input  logic [2:0]       regaddress_in,
    input  logic [WIDTH-1:0] address_in,
    input  logic [WIDTH-1:0] storedata_in,
    input  logic             isbranchout_in,
    input  logic [2:0]       condout_in,
    input  logic [WIDTH-1:0] pc_in,
    output logic             valid_out,
    output logic [WIDTH-1:0] aluresult,
    output logic             writereg_out,
    output logic [1:0]       memwrite_out,
    output logic [2:0]       regaddress_out,
    output logic [WIDTH-1:0] address_out,
    output logic [WIDTH-1:0] storedata_out,
    output logic [3:0]       flags,
    output logic             branch_taken,
    output logic [WIDTH-1:0] branch_target,
    output logic [WIDTH-1:0] outdata,
    output logic             outvalid,
    output logic             halted
);

    // Pipeline register state
    logic             valid_q, valid_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             wr_q, wr_d;
    logic [1:0]       mw_q, mw_d;
    logic [2:0]       ra_q, ra_d;
    logic [WIDTH-1:0] addr_q, addr_d;
    logic [WIDTH-1:0] sdata_q, sdata_d;
    logic [3:0]       flags_q, flags_d;
    logic             bt_q, bt_d;
    logic [WIDTH-1:0] btgt_q, btgt_d;
    logic [WIDTH-1:0] od_q, od_d;
    logic             ov_q, ov_d;
    logic             halted_q, halted_d;

    // ALU datapath
    logic [WIDTH-1:0] a, b;
    logic [3:0]       d;
    logic [WIDTH:0]   sum, diff, sh_l, sh_r;
    logic signed [WIDTH:0] sh_a;
    logic [WIDTH-1:0] rot;
    logic [4:0]       rot_back;
    logic [WIDTH-1:0] alu_res;
    logic             alu_c, alu_v;
    logic             flag_upd;   // opcode writes the flag register
    logic             wr_kill;    // opcode never writes a register
    logic             go, br_cond;

    assign a = alu1;
    assign b = alu2;
    assign d = alu2[3:0];
    assign go = valid_in & ~flush & ~halted_q;

    always_comb begin
        // Extra low bit on the right shifts catches the last bit shifted out.
        sum      = {1'b0, a} + {1'b0, b};
        diff     = {1'b0, b} - {1'b0, a};     // MSB is the borrow (b < a)
        sh_l     = {1'b0, b} << d;
        sh_r     = {b, 1'b0} >> d;
        sh_a     = $signed({b, 1'b0}) >>> d;
        rot_back = 5'(WIDTH) - {1'b0, d};
        rot      = (b << d) | (b >> rot_back);  // d=0: b>>16 is zero
        alu_res  = '0;
        alu_c    = 1'b0;
        alu_v    = 1'b0;
        flag_upd = 1'b1;
        wr_kill  = 1'b0;
        case (opcode)
            4'd0: begin
                alu_res = sum[WIDTH-1:0];
                alu_c   = sum[WIDTH];
                alu_v   = (a[WIDTH-1] == b[WIDTH-1]) & (sum[WIDTH-1] != a[WIDTH-1]);
            end
            4'd1, 4'd5: begin
                alu_res = diff[WIDTH-1:0];
                alu_c   = diff[WIDTH];
                alu_v   = (a[WIDTH-1] != b[WIDTH-1]) & (diff[WIDTH-1] != b[WIDTH-1]);
                wr_kill = (opcode == 4'd5);
            end
            4'd2: alu_res = b & a;
            4'd3: alu_res = b | a;
            4'd4: alu_res = b ^ a;
            4'd6: alu_res = a;
            4'd8: begin
                alu_res = sh_l[WIDTH-1:0];
                alu_c   = sh_l[WIDTH];
            end
            4'd9: begin
                alu_res = rot;
                alu_c   = (d != 4'd0) & rot[0];   // bit that wrapped around last
            end
            4'd10: begin
                alu_res = sh_r[WIDTH:1];
                alu_c   = sh_r[0];
            end
            4'd11: begin
                alu_res = sh_a[WIDTH:1];
                alu_c   = sh_a[0];
            end
            4'd12: flag_upd = 1'b0;              // IN: no input port, result 0
            4'd13: begin                         // OUT
                alu_res  = a;
                flag_upd = 1'b0;
                wr_kill  = 1'b1;
            end
            default: begin                       // 7, 14 reserved; 15 HLT
                flag_upd = 1'b0;
                wr_kill  = 1'b1;
            end
        endcase
    end

    // Branch condition uses the flag register as it stands before this edge.
    always_comb begin
        br_cond = 1'b0;
        case (condout_in)
            3'b000: br_cond = flags_q[2];
            3'b001: br_cond = flags_q[3] ^ flags_q[0];
            3'b010: br_cond = flags_q[2] | (flags_q[3] ^ flags_q[0]);
            3'b011: br_cond = ~flags_q[2];
            3'b100, 3'b111: br_cond = 1'b1;
            default: br_cond = 1'b0;
        endcase
    end

    always_comb begin
        // Pulses and write enables clear on idle cycles; data fields hold.
        valid_d  = 1'b0;
        wr_d     = 1'b0;
        mw_d     = 2'b00;
        bt_d     = 1'b0;
        ov_d     = 1'b0;
        result_d = result_q;
        ra_d     = ra_q;
        addr_d   = addr_q;
        sdata_d  = sdata_q;
        flags_d  = flags_q;
        btgt_d   = btgt_q;
        od_d     = od_q;
        halted_d = halted_q;
        if (go) begin
            valid_d  = 1'b1;
            ra_d     = regaddress_in;
            addr_d   = address_in;
            sdata_d  = storedata_in;
            wr_d     = writereg_in & ~(alu_class & wr_kill) & ~isbranchout_in;
            mw_d     = isbranchout_in ? 2'b00 : memwrite_in;
            result_d = alu_class ? alu_res : address_in;
            if (alu_class && flag_upd) begin
                flags_d = {alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v};
            end
            if (isbranchout_in && br_cond) begin
                bt_d   = 1'b1;
                btgt_d = pc_in + address_in;
            end
            if (alu_class && opcode == 4'd13) begin
                od_d = a;
                ov_d = 1'b1;
            end
            if (alu_class && opcode == 4'd15) begin
                halted_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clockp3) begin
        if (reset) begin
            valid_q  <= 1'b0;
            result_q <= '0;
            wr_q     <= 1'b0;
            mw_q     <= 2'b00;
            ra_q     <= '0;
            addr_q   <= '0;
            sdata_q  <= '0;
            flags_q  <= '0;
            bt_q     <= 1'b0;
            btgt_q   <= '0;
            od_q     <= '0;
            ov_q     <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            valid_q  <= valid_d;
            result_q <= result_d;
            wr_q     <= wr_d;
            mw_q     <= mw_d;
            ra_q     <= ra_d;
            addr_q   <= addr_d;
            sdata_q  <= sdata_d;
            flags_q  <= flags_d;
            bt_q     <= bt_d;
            btgt_q   <= btgt_d;
            od_q     <= od_d;
            ov_q     <= ov_d;
            halted_q <= halted_d;
        end
    end

    assign valid_out      = valid_q;
    assign aluresult      = result_q;
    assign writereg_out   = wr_q;
    assign memwrite_out   = mw_q;
    assign regaddress_out = ra_q;
    assign address_out    = addr_q;
    assign storedata_out  = sdata_q;
    assign flags          = flags_q;
    assign branch_taken   = bt_q;
    assign branch_target  = btgt_q;
    assign outdata        = od_q;
    assign outvalid       = ov_q;
    assign halted         = halted_q;

endmodule

// File: tb/tb_p3_exec_stage.sv
// Testbench for p3_exec_stage: each cycle drives one input set, pushes the
// expected p4 register contents to a scoreboard and pops/compares after the
// following posedge.
module tb_p3_exec_stage;

    logic        clockp3, reset, valid_in, flush, alu_class;
    logic [15:0] alu1, alu2;
    logic [3:0]  opcode;
    logic        writereg_in;
    logic [1:0]  memwrite_in;
    logic [2:0]  regaddress_in;
    logic [15:0] address_in, storedata_in;
    logic        isbranchout_in;
    logic [2:0]  condout_in;
    logic [15:0] pc_in;
    logic        valid_out, writereg_out, branch_taken, outvalid, halted;
    logic [15:0] aluresult, address_out, storedata_out, branch_target, outdata;
    logic [1:0]  memwrite_out;
    logic [2:0]  regaddress_out;
    logic [3:0]  flags;

    p3_exec_stage #(.WIDTH(16)) dut (
        .clockp3(clockp3), .reset(reset), .valid_in(valid_in), .flush(flush),
        .alu_class(alu_class), .alu1(alu1), .alu2(alu2), .opcode(opcode),
        .writereg_in(writereg_in), .memwrite_in(memwrite_in),
        .regaddress_in(regaddress_in), .address_in(address_in),
        .storedata_in(storedata_in), .isbranchout_in(isbranchout_in),
        .condout_in(condout_in), .pc_in(pc_in),
        .valid_out(valid_out), .aluresult(aluresult), .writereg_out(writereg_out),
        .memwrite_out(memwrite_out), .regaddress_out(regaddress_out),
        .address_out(address_out), .storedata_out(storedata_out), .flags(flags),
        .branch_taken(branch_taken), .branch_target(branch_target),
        .outdata(outdata), .outvalid(outvalid), .halted(halted)
    );

    initial clockp3 = 1'b0;
    always #5 clockp3 = ~clockp3;

    typedef struct {
        logic        v;
        logic [15:0] res;
        logic        chk_res;
        logic        wr;
        logic [1:0]  mw;
        logic [3:0]  fl;
        logic        bt;
        logic [15:0] tgt;
        logic        ov;
        logic [15:0] od;
        logic        hlt;
        logic [2:0]  ra;
        logic [15:0] ad;
        logic [15:0] sd;
    } exp_t;

    exp_t sb[$];
    int   total = 0;
    int   bad   = 0;
    int   txn   = 0;

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL txn%0d %s got=%h exp=%h", txn, tag, got, exp);
        end
    endtask

    task automatic drive(input logic v, input logic fl, input logic cls,
                         input logic [15:0] a, input logic [15:0] b,
                         input logic [3:0] op, input logic wr, input logic [1:0] mw,
                         input logic [2:0] ra, input logic [15:0] ad,
                         input logic [15:0] sd, input logic br,
                         input logic [2:0] cnd, input logic [15:0] pc);
        valid_in = v; flush = fl; alu_class = cls; alu1 = a; alu2 = b;
        opcode = op; writereg_in = wr; memwrite_in = mw; regaddress_in = ra;
        address_in = ad; storedata_in = sd; isbranchout_in = br;
        condout_in = cnd; pc_in = pc;
    endtask

    task automatic expect_out(input logic v, input logic [15:0] res, input logic chk_res,
                              input logic wr, input logic [1:0] mw, input logic [3:0] fl,
                              input logic bt, input logic [15:0] tgt, input logic ov,
                              input logic [15:0] od, input logic hlt,
                              input logic [2:0] ra, input logic [15:0] ad,
                              input logic [15:0] sd);
        exp_t e;
        e.v = v; e.res = res; e.chk_res = chk_res; e.wr = wr; e.mw = mw;
        e.fl = fl; e.bt = bt; e.tgt = tgt; e.ov = ov; e.od = od; e.hlt = hlt;
        e.ra = ra; e.ad = ad; e.sd = sd;
        sb.push_back(e);
    endtask

    task automatic step();
        exp_t e;
        @(posedge clockp3);
        #1;
        check("sb_depth", 16'(sb.size()), 16'd1);
        if (sb.size() > 0) begin
            e = sb.pop_front();
            check("valid_out", {15'd0, valid_out}, {15'd0, e.v});
            if (e.chk_res) check("aluresult", aluresult, e.res);
            check("writereg_out", {15'd0, writereg_out}, {15'd0, e.wr});
            check("memwrite_out", {14'd0, memwrite_out}, {14'd0, e.mw});
            check("flags", {12'd0, flags}, {12'd0, e.fl});
            check("branch_taken", {15'd0, branch_taken}, {15'd0, e.bt});
            check("branch_target", branch_target, e.tgt);
            check("outvalid", {15'd0, outvalid}, {15'd0, e.ov});
            check("outdata", outdata, e.od);
            check("halted", {15'd0, halted}, {15'd0, e.hlt});
            if (e.v) begin
                check("regaddress_out", {13'd0, regaddress_out}, {13'd0, e.ra});
                check("address_out", address_out, e.ad);
                check("storedata_out", storedata_out, e.sd);
            end
        end
        $display("txn %0d: v=%b res=%h wr=%b mw=%b fl=%b bt=%b tgt=%h ov=%b od=%h hlt=%b",
                 txn, valid_out, aluresult, writereg_out, memwrite_out, flags,
                 branch_taken, branch_target, outvalid, outdata, halted);
        txn++;
    endtask

    initial begin
        // Reset
        reset = 1'b1;
        drive(0, 0, 0, 16'h0, 16'h0, 4'd0, 0, 2'b00, 3'd0, 16'h0, 16'h0, 0, 3'd0, 16'h0);
        expect_out(0, 16'h0000, 1, 0, 2'b00, 4'b0000, 0, 16'h0000, 0, 16'h0000, 0, 3'd0, 16'h0, 16'h0);
        step();
        reset = 1'b0;

        // ADD 0x7FFF + 0x0001: signed overflow
        drive(1, 0, 1, 16'h7FFF, 16'h0001, 4'd0, 1, 2'b00, 3'd3, 16'h0040, 16'h1111, 0, 3'd0, 16'h0005);
        expect_out(1, 16'h8000, 1, 1, 2'b00, 4'b1001, 0, 16'h0000, 0, 16'h0000, 0, 3'd3, 16'h0040, 16'h1111);
        step();
        // SUB b-a = 3-5: borrow, negative
        drive(1, 0, 1, 16'h0005, 16'h0003, 4'd1, 1, 2'b00, 3'd4, 16'h0000, 16'h0000, 0, 3'd0, 16'h0006);
        expect_out(1, 16'hFFFE, 1, 1, 2'b00, 4'b1010, 0, 16'h0000, 0, 16'h0000, 0, 3'd4, 16'h0000, 16'h0000);
        step();
        // BLT taken on S^V=1; target wraps to 0x000C; writereg forced off
        drive(1, 0, 0, 16'h0, 16'h0, 4'd0, 1, 2'b00, 3'd5, 16'hFFFC, 16'h0000, 1, 3'b001, 16'h0010);
        expect_out(1, 16'hFFFC, 1, 0, 2'b00, 4'b1010, 1, 16'h000C, 0, 16'h0000, 0, 3'd5, 16'hFFFC, 16'h0000);
        step();
        // Idle: pulse drops, target and result hold
        drive(0, 0, 0, 16'h0, 16'h0, 4'd0, 0, 2'b00, 3'd0, 16'h0, 16'h0, 0, 3'd0, 16'h0);
        expect_out(0, 16'hFFFC, 1, 0, 2'b00, 4'b1010, 0, 16'h000C, 0, 16'h0000, 0, 3'd0, 16'h0, 16'h0);
        step();
        // SRA 0x8001 by 1 -> 0xC000, C=1
        drive(1, 0, 1, 16'h0, 16'h8001, 4'd11, 1, 2'b00, 3'd1, 16'h0, 16'h0, 0, 3'd0, 16'h0);
        expect_out(1, 16'hC000, 1, 1, 2'b00, 4'b1010, 0, 16'h000C, 0, 16'h0000, 0, 3'd1, 16'h0, 16'h0);
        step();
        // SLR (rotate) 0x8004 by 4 -> 0x0048, C=0
        drive(1, 0, 1, 16'h0, 16'h8004, 4'd9, 1, 2'b00, 3'd2, 16'h0, 16'h0, 0, 3'd0, 16'h0);
        expect_out(1, 16'h0048, 1, 1, 2'b00, 4'b0000, 0, 16'h000C, 0, 16'h0000, 0, 3'd2, 16'h0, 16'h0);
        step();
        // SRL 0x00F7 by 7 -> 0x0001, C=bit6=1
        drive(1, 0, 1, 16'h0, 16'h00F7, 4'd10, 1, 2'b00, 3'd2, 16'h0, 16'h0, 0, 3'd0, 16'h0);
        expect_out(1, 16'h0001, 1, 1, 2'b00, 4'b0010, 0, 16'h000C, 0, 16'h0000, 0, 3'd2, 16'h0, 16'h0);
        step();
        // SLL 0x701C by 12 -> 0xC000, C=bit4=1
        drive(1, 0, 1, 16'h0, 16'h701C, 4'd8, 1, 2'b00, 3'd2, 16'h0, 16'h0, 0, 3'd0, 16'h0);
        expect_out(1, 16'hC000, 1, 1, 2'b00, 4'b1010, 0, 16'h000C, 0, 16'h0000, 0, 3'd2, 16'h0, 16'h0);
        step();
        // CMP equal operands: Z=1, no register write
        drive(1, 0, 1, 16'h1234, 16'h1234, 4'd5, 1, 2'b00, 3'd6, 16'h0, 16'h0, 0, 3'd0, 16'h0);
        expect_out(1, 16'h0000, 1, 0, 2'b00, 4'b0100, 0, 16'h000C, 0, 16'h0000, 0, 3'd6, 16'h0, 16'h0);
        step();
        // BNE with Z=1: not taken, still retires
        drive(1, 0, 0, 16'h0, 16'h0, 4'd0, 0, 2'b00, 3'd0, 16'h0005, 16'h0, 1, 3'b011, 16'h0020);
        expect_out(1, 16'h0005, 1, 0, 2'b00, 4'b0100, 0, 16'h000C, 0, 16'h0000, 0, 3'd0, 16'h0005, 16'h0);
        step();
        // Flushed ADD: dropped, flags unchanged
        drive(1, 1, 1, 16'h0001, 16'h0001, 4'd0, 1, 2'b00, 3'd1, 16'h0, 16'h0, 0, 3'd0, 16'h0);
        expect_out(0, 16'h0005, 1, 0, 2'b00, 4'b0100, 0, 16'h000C, 0, 16'h0000, 0, 3'd0, 16'h0, 16'h0);
        step();
        // OUT 0xBEEF
        drive(1, 0, 1, 16'hBEEF, 16'h0000, 4'd13, 1, 2'b00, 3'd7, 16'h0, 16'h0, 0, 3'd0, 16'h0);
        expect_out(1, 16'h0000, 0, 0, 2'b00, 4'b0100, 0, 16'h000C, 1, 16'hBEEF, 0, 3'd7, 16'h0, 16'h0);
        step();
        // Idle: outvalid lasted one cycle, outdata holds
        drive(0, 0, 0, 16'h0, 16'h0, 4'd0, 0, 2'b00, 3'd0, 16'h0, 16'h0, 0, 3'd0, 16'h0);
        expect_out(0, 16'h0000, 0, 0, 2'b00, 4'b0100, 0, 16'h000C, 0, 16'hBEEF, 0, 3'd0, 16'h0, 16'h0);
        step();
        // HLT retires
        drive(1, 0, 1, 16'h0, 16'h0, 4'd15, 1, 2'b00, 3'd1, 16'h0, 16'h0, 0, 3'd0, 16'h0);
        expect_out(1, 16'h0000, 0, 0, 2'b00, 4'b0100, 0, 16'h000C, 0, 16'hBEEF, 1, 3'd1, 16'h0, 16'h0);
        step();
        // ADD after HLT: dropped
        drive(1, 0, 1, 16'h0001, 16'h0001, 4'd0, 1, 2'b00, 3'd1, 16'h0, 16'h0, 0, 3'd0, 16'h0);
        expect_out(0, 16'h0000, 0, 0, 2'b00, 4'b0100, 0, 16'h000C, 0, 16'hBEEF, 1, 3'd0, 16'h0, 16'h0);
        step();
        // Flush while halted: still inert
        drive(1, 1, 1, 16'h0001, 16'h0001, 4'd13, 1, 2'b00, 3'd1, 16'h0, 16'h0, 0, 3'd0, 16'h0);
        expect_out(0, 16'h0000, 0, 0, 2'b00, 4'b0100, 0, 16'h000C, 0, 16'hBEEF, 1, 3'd0, 16'h0, 16'h0);
        step();
        // Reset with a valid ADD present: reset wins
        reset = 1'b1;
        drive(1, 0, 1, 16'h0001, 16'h0001, 4'd0, 1, 2'b01, 3'd1, 16'h1, 16'h1, 0, 3'd0, 16'h0);
        expect_out(0, 16'h0000, 1, 0, 2'b00, 4'b0000, 0, 16'h0000, 0, 16'h0000, 0, 3'd0, 16'h0, 16'h0);
        step();
        reset = 1'b0;
        // ADD 0xFFFF + 1: carry out, zero result
        drive(1, 0, 1, 16'hFFFF, 16'h0001, 4'd0, 1, 2'b00, 3'd2, 16'h0033, 16'h0044, 0, 3'd0, 16'h0);
        expect_out(1, 16'h0000, 1, 1, 2'b00, 4'b0110, 0, 16'h0000, 0, 16'h0000, 0, 3'd2, 16'h0033, 16'h0044);
        step();
        // BE taken on Z=1; memwrite forced to 00
        drive(1, 0, 0, 16'h0, 16'h0, 4'd0, 0, 2'b10, 3'd0, 16'h0002, 16'h0, 1, 3'b000, 16'h0100);
        expect_out(1, 16'h0002, 1, 0, 2'b00, 4'b0110, 1, 16'h0102, 0, 16'h0000, 0, 3'd0, 16'h0002, 16'h0);
        step();
        // flush and valid together on a branch: no pulse
        drive(1, 1, 0, 16'h0, 16'h0, 4'd0, 0, 2'b00, 3'd0, 16'h0009, 16'h0, 1, 3'b100, 16'h0200);
        expect_out(0, 16'h0002, 1, 0, 2'b00, 4'b0110, 0, 16'h0102, 0, 16'h0000, 0, 3'd0, 16'h0, 16'h0);
        step();
        // Non-ALU load: result is the address, pass-through fields
        drive(1, 0, 0, 16'h0, 16'h0, 4'd0, 1, 2'b01, 3'd5, 16'hABCD, 16'h5555, 0, 3'd0, 16'h0);
        expect_out(1, 16'hABCD, 1, 1, 2'b01, 4'b0110, 0, 16'h0102, 0, 16'h0000, 0, 3'd5, 16'hABCD, 16'h5555);
        step();
        // Reserved opcode 7: result 0, flags kept, no write
        drive(1, 0, 1, 16'h0003, 16'h0003, 4'd7, 1, 2'b00, 3'd6, 16'h0, 16'h0, 0, 3'd0, 16'h0);
        expect_out(1, 16'h0000, 1, 0, 2'b00, 4'b0110, 0, 16'h0102, 0, 16'h0000, 0, 3'd6, 16'h0, 16'h0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
